// File: rtl/spwm_pkg.sv
// Shared definitions for the SPWM sequencer slice.
// Holds the sequencer state encoding, the quadrant encoding seen on the
// Quadrant output, the default carrier period and the datapath widths.
package spwm_pkg;

    localparam int PWM_PERIOD_DEFAULT = 10000; // 50 MHz / 5 kHz carrier
    localparam int FREC_W   = 8;               // user frequency
    localparam int CICLOS_W = 11;              // carrier periods per quarter cycle
    localparam int CTE_W    = 16;              // duty step per carrier period
    localparam int DUTY_W   = 14;              // duty and carrier counter

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOAD,
        RISE_P,
        FALL_P,
        RISE_N,
        FALL_N
    } state_t;

    typedef enum logic [1:0] {
        Q_RISE_P = 2'd0,
        Q_FALL_P = 2'd1,
        Q_RISE_N = 2'd2,
        Q_FALL_N = 2'd3
    } quadrant_t;

endpackage

// File: rtl/spwm_sequencer_if.sv
// Signal bundle between the SPWM sequencer and its surroundings.
//   master : run request, user frequency, calculator results in; status out
//   slave  : the sequencer side of the same signals
// Ciclos_pwm and Cte come from the frequency calculator, which is driven
// combinationally by Frec_sel.
interface spwm_sequencer_if;
    import spwm_pkg::*;

    logic                Enable;
    logic [FREC_W-1:0]   Frec;
    logic [CICLOS_W-1:0] Ciclos_pwm;
    logic [CTE_W-1:0]    Cte;
    logic [FREC_W-1:0]   Frec_sel;
    logic                PWM_A;
    logic                PWM_B;
    logic [DUTY_W-1:0]   Duty;
    logic [1:0]          Quadrant;
    logic                Period_tick;
    logic                Cycle_done;
    logic                Busy;

    modport master (
        output Enable, Frec, Ciclos_pwm, Cte,
        input  Frec_sel, PWM_A, PWM_B, Duty, Quadrant, Period_tick, Cycle_done, Busy
    );

    modport slave (
        input  Enable, Frec, Ciclos_pwm, Cte,
        output Frec_sel, PWM_A, PWM_B, Duty, Quadrant, Period_tick, Cycle_done, Busy
    );

endinterface

// File: rtl/spwm_carrier.sv
// PWM carrier: free-running period counter plus registered gate comparator.
//   clk, rst_n   : clock, synchronous active-low reset
//   run          : counter advances while high, held at 0 otherwise
//   leg_a, leg_b : which gate the comparison is steered to
//   duty         : high time in clocks for the current period
//   period_tick  : high on the last clock of each carrier period
//   pwm_a, pwm_b : registered gates, one clock behind per_cnt/duty
module spwm_carrier
    import spwm_pkg::*;
#(
    parameter int PWM_PERIOD = PWM_PERIOD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              leg_a,
    input  logic              leg_b,
    input  logic [DUTY_W-1:0] duty,
    output logic              period_tick,
    output logic              pwm_a,
    output logic              pwm_b
);

    logic [DUTY_W-1:0] per_cnt;

    assign period_tick = run && (per_cnt == DUTY_W'(PWM_PERIOD - 1));

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; dropping rst_n
        // between edges leaves every register untouched.
        if (!rst_n) begin
            per_cnt <= '0;
            pwm_a   <= 1'b0;
            pwm_b   <= 1'b0;
        end else begin
            // Counter idles at 0 so the first quadrant period starts cleanly.
            if (!run || period_tick) begin
                per_cnt <= '0;
            end else begin
                per_cnt <= per_cnt + 1'b1;
            end
            // duty == PWM_PERIOD keeps the gate high for the whole period.
            pwm_a <= leg_a && (per_cnt < duty);
            pwm_b <= leg_b && (per_cnt < duty);
        end
    end

endmodule

// File: rtl/spwm_sequencer.sv
// SPWM sequencer: latches the user frequency, loads the calculator results
// and ramps duty through RISE_P, FALL_P, RISE_N, FALL_N. A new frequency is
// only picked up at the end of FALL_N, so a cycle is never torn.
//   Clk   : 50 MHz system clock
//   Rst_n : synchronous active-low reset
//   sif   : slave side of spwm_sequencer_if (run request, frequency,
//           calculator results in; gates, duty, quadrant, ticks, busy out)
module spwm_sequencer
    import spwm_pkg::*;
#(
    parameter int PWM_PERIOD = PWM_PERIOD_DEFAULT
) (
    input  logic            Clk,
    input  logic            Rst_n,
    spwm_sequencer_if.slave sif
);

    state_t              state;
    state_t              next_state;
    quadrant_t           quadrant;
    logic [FREC_W-1:0]   frec_sel;
    logic [CICLOS_W-1:0] ciclos_q;
    logic [CICLOS_W-1:0] quad_cnt;
    logic [CTE_W-1:0]    cte_q;
    logic [DUTY_W-1:0]   duty;
    logic [DUTY_W-1:0]   duty_up;
    logic [DUTY_W-1:0]   duty_dn;
    logic [CTE_W:0]      duty_sum;
    logic                start_ok;
    logic                last_period;
    logic                period_tick;
    logic                run;
    logic                leg_a;
    logic                leg_b;
    logic                rising;
    logic                pwm_a;
    logic                pwm_b;

    spwm_carrier #(.PWM_PERIOD(PWM_PERIOD)) u_carrier (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .run         (run),
        .leg_a       (leg_a),
        .leg_b       (leg_b),
        .duty        (duty),
        .period_tick (period_tick),
        .pwm_a       (pwm_a),
        .pwm_b       (pwm_b)
    );

    // Frec == 0 would divide by zero in the calculator, so it never starts a cycle.
    assign start_ok    = sif.Enable && (sif.Frec != '0);
    assign last_period = period_tick && (quad_cnt == ciclos_q - 1'b1);

    assign leg_a  = (state == RISE_P) || (state == FALL_P);
    assign leg_b  = (state == RISE_N) || (state == FALL_N);
    assign run    = leg_a || leg_b;
    assign rising = (state == RISE_P) || (state == RISE_N);

    // Sum is one bit wider than the step so the saturation test cannot wrap.
    assign duty_sum = {1'b0, cte_q} + (CTE_W + 1)'(duty);
    assign duty_up  = (duty_sum > (CTE_W + 1)'(PWM_PERIOD)) ? DUTY_W'(PWM_PERIOD)
                                                             : duty_sum[DUTY_W-1:0];
    assign duty_dn  = (cte_q >= CTE_W'(duty)) ? '0 : duty - cte_q[DUTY_W-1:0];

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves an output
        // unassigned and infers a latch.
        next_state = state;
        quadrant   = Q_RISE_P;
        case (state)
            IDLE:    if (start_ok) next_state = LATCH;
            LATCH:   next_state = LOAD;
            LOAD:    next_state = RISE_P;
            RISE_P:  if (last_period) next_state = FALL_P;
            FALL_P: begin
                quadrant = Q_FALL_P;
                if (last_period) next_state = RISE_N;
            end
            RISE_N: begin
                quadrant = Q_RISE_N;
                if (last_period) next_state = FALL_N;
            end
            FALL_N: begin
                quadrant = Q_FALL_N;
                if (last_period) next_state = start_ok ? LATCH : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            frec_sel <= '0;
            ciclos_q <= '0;
            cte_q    <= '0;
            quad_cnt <= '0;
            duty     <= '0;
        end else begin
            case (state)
                LATCH: frec_sel <= sif.Frec;
                LOAD: begin
                    // A zero count from the calculator runs one period per quadrant.
                    ciclos_q <= (sif.Ciclos_pwm == '0) ? CICLOS_W'(1) : sif.Ciclos_pwm;
                    cte_q    <= sif.Cte;
                    quad_cnt <= '0;
                    duty     <= '0;
                end
                default: begin
                    if (period_tick) begin
                        quad_cnt <= last_period ? '0 : quad_cnt + 1'b1;
                        if (last_period && !rising) begin
                            duty <= '0;
                        end else if (rising) begin
                            duty <= duty_up;
                        end else begin
                            duty <= duty_dn;
                        end
                    end
                end
            endcase
        end
    end

    assign sif.Frec_sel    = frec_sel;
    assign sif.Duty        = duty;
    assign sif.Quadrant    = quadrant;
    assign sif.PWM_A       = pwm_a;
    assign sif.PWM_B       = pwm_b;
    assign sif.Period_tick = period_tick;
    assign sif.Cycle_done  = (state == FALL_N) && last_period;
    assign sif.Busy        = (state != IDLE);

endmodule

// File: tb/tb_spwm_sequencer.sv
// Directed bench for spwm_sequencer. The carrier period is shortened to
// 100 clocks and the calculator steps are scaled to match, so every duty
// value is the full-size value divided by 100.
module tb_spwm_sequencer;
    import spwm_pkg::*;

    localparam int P = 100;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    spwm_sequencer_if sif();

    spwm_sequencer #(.PWM_PERIOD(P)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .sif   (sif)
    );

    always #5 Clk = ~Clk;

    // Frequency calculator stand-in, driven from the latched frequency.
    always_comb begin
        sif.Ciclos_pwm = 11'd1;
        sif.Cte        = 16'd10;
        case (sif.Frec_sel)
            8'd125: begin sif.Ciclos_pwm = 11'd10; sif.Cte = 16'd10; end
            8'd250: begin sif.Ciclos_pwm = 11'd5;  sif.Cte = 16'd20; end
            8'd50:  begin sif.Ciclos_pwm = 11'd4;  sif.Cte = 16'd40; end
            8'd60:  begin sif.Ciclos_pwm = 11'd0;  sif.Cte = 16'd10; end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_pass   = 0;

    int tick_duty [64];
    int tick_quad [64];
    int tick_t    [64];
    int n_ticks, done_t, sum_a, sum_b, overlap, sel_at1, sel_changes, gap_hi;

    int exp_sat [16] = '{0, 40, 80, 100, 100, 60, 20, 0, 0, 40, 80, 100, 100, 60, 20, 0};
    int exp_one [4]  = '{0, 10, 0, 10};

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Duty of tick i for a cycle of c periods per quadrant and step cte.
    function automatic int exp_ramp(input int i, input int c, input int cte);
        int k    = i % c;
        int quad = i / c;
        int peak = (c * cte > P) ? P : c * cte;
        if (quad % 2 == 0) return (k * cte > P) ? P : k * cte;
        return (peak - k * cte < 0) ? 0 : peak - k * cte;
    endfunction

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (sif.Busy) break;
        end
        check("start_busy", int'(sif.Busy), 1);
    endtask

    // Entered at the negedge of the LATCH clock (t = 0); returns at the
    // negedge one clock after Cycle_done.
    task automatic run_cycle(input int budget, input int switch_t, input int frec_new,
                             input int drop_t);
        int t;
        bit done;
        n_ticks = 0; done_t = -1; sum_a = 0; sum_b = 0; overlap = 0;
        sel_at1 = -1; sel_changes = 0; gap_hi = 0;
        done = 1'b0;
        t = 0;
        while (t < budget) begin
            @(negedge Clk);
            t++;
            if (t == switch_t) sif.Frec = FREC_W'(frec_new);
            if (t == drop_t) sif.Enable = 1'b0;
            sum_a += int'(sif.PWM_A);
            sum_b += int'(sif.PWM_B);
            if (sif.PWM_A && sif.PWM_B) overlap++;
            if (t <= 2 && (sif.PWM_A || sif.PWM_B)) gap_hi++;
            if (t == 1) sel_at1 = int'(sif.Frec_sel);
            else if (int'(sif.Frec_sel) != sel_at1) sel_changes++;
            if (done) break;
            if (sif.Period_tick && n_ticks < 64) begin
                tick_duty[n_ticks] = int'(sif.Duty);
                tick_quad[n_ticks] = int'(sif.Quadrant);
                tick_t[n_ticks]    = t;
                n_ticks++;
            end
            if (sif.Cycle_done) begin
                done   = 1'b1;
                done_t = t;
            end
        end
        check("cycle_done_seen", int'(done), 1);
    endtask

    task automatic check_ramp(input string tag, input int c, input int cte);
        for (int i = 0; i < 4 * c && i < n_ticks; i++) begin
            check({tag, "_duty"}, tick_duty[i], exp_ramp(i, c, cte));
            check({tag, "_quad"}, tick_quad[i], i / c);
        end
    endtask

    initial begin
        int busy_seen;
        sif.Enable = 1'b0;
        sif.Frec   = '0;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_frec_sel", int'(sif.Frec_sel), 0);
        check("rst_duty", int'(sif.Duty), 0);
        check("rst_pwm", int'({sif.PWM_A, sif.PWM_B}), 0);
        check("rst_quadrant", int'(sif.Quadrant), 0);
        check("rst_ticks", int'({sif.Period_tick, sif.Cycle_done}), 0);
        check("rst_busy", int'(sif.Busy), 0);

        // Basic ramp at Frec=125 (10 periods, step 10)
        Rst_n      = 1'b1;
        sif.Enable = 1'b1;
        sif.Frec   = 8'd125;
        wait_start(10);
        run_cycle(6000, -1, 0, -1);
        check("t1_frec_sel", sel_at1, 125);
        check("t1_ticks", n_ticks, 40);
        check("t1_done_t", done_t, 4001);
        check("t1_sum_a", sum_a, 1000);
        check("t1_sum_b", sum_b, 1000);
        check("t1_overlap", overlap, 0);
        check_ramp("t1", 10, 10);

        // Frequency change mid-FALL_P is deferred to the boundary
        run_cycle(6000, 1500, 250, -1);
        check("t3_sel_held", sel_at1, 125);
        check("t3_sel_changes", sel_changes, 0);
        check("t3_ticks_old", n_ticks, 40);
        check("t3_done_old", done_t, 4001);
        check_ramp("t3_old", 10, 10);

        // New frequency cycle; Enable dropped during RISE_N
        run_cycle(3000, -1, 0, 1200);
        check("t3_sel_new", sel_at1, 250);
        check("t3_gap_low", gap_hi, 0);
        check("t3_ticks_new", n_ticks, 20);
        check("t4_done_t", done_t, 2001);
        check("t3_sum_a", sum_a, 500);
        check("t3_sum_b", sum_b, 500);
        check_ramp("t3_new", 5, 20);
        check("t4_busy", int'(sif.Busy), 0);
        check("t4_quadrant", int'(sif.Quadrant), 0);
        @(negedge Clk);
        check("t4_pwm_low", int'({sif.PWM_A, sif.PWM_B}), 0);
        check("t4_duty", int'(sif.Duty), 0);

        // Frec = 0 never leaves IDLE
        sif.Frec   = 8'd0;
        sif.Enable = 1'b1;
        busy_seen  = 0;
        repeat (20) begin
            @(negedge Clk);
            busy_seen += int'(sif.Busy);
        end
        check("t4_frec0_idle", busy_seen, 0);

        // Saturation and floor (4 periods, step 40)
        sif.Frec = 8'd50;
        wait_start(10);
        run_cycle(3000, -1, 0, 5);
        check("t2_ticks", n_ticks, 16);
        check("t2_done_t", done_t, 1601);
        check("t2_sum_a", sum_a, 400);
        check("t2_sum_b", sum_b, 400);
        for (int i = 0; i < 16 && i < n_ticks; i++) check("t2_duty", tick_duty[i], exp_sat[i]);
        check("t2_busy_after", int'(sif.Busy), 0);

        // Ciclos_pwm = 0 runs one period per quadrant
        sif.Enable = 1'b1;
        sif.Frec   = 8'd60;
        wait_start(10);
        run_cycle(1000, -1, 0, 5);
        check("t6_ticks", n_ticks, 4);
        check("t6_done_t", done_t, 401);
        check("t6_overlap", overlap, 0);
        check("t6_sum_a", sum_a, 10);
        check("t6_sum_b", sum_b, 10);
        for (int i = 0; i < 4 && i < n_ticks; i++) begin
            check("t6_tick_t", tick_t[i], 101 + 100 * i);
            check("t6_quad", tick_quad[i], i);
            check("t6_duty", tick_duty[i], exp_one[i]);
        end

        // Reset during FALL_P with PWM_A high
        sif.Enable = 1'b1;
        sif.Frec   = 8'd125;
        wait_start(10);
        repeat (1050) @(negedge Clk);
        check("t5_pwm_a_pre", int'(sif.PWM_A), 1);
        check("t5_quad_pre", int'(sif.Quadrant), 1);
        Rst_n = 1'b0;
        #2;
        check("t5_no_edge_pwm_a", int'(sif.PWM_A), 1);
        check("t5_no_edge_busy", int'(sif.Busy), 1);
        check("t5_no_edge_sel", int'(sif.Frec_sel), 125);
        check("t5_no_edge_duty", int'(sif.Duty), 100);
        @(negedge Clk);
        check("t5_pwm", int'({sif.PWM_A, sif.PWM_B}), 0);
        check("t5_frec_sel", int'(sif.Frec_sel), 0);
        check("t5_duty", int'(sif.Duty), 0);
        check("t5_busy", int'(sif.Busy), 0);
        check("t5_quadrant", int'(sif.Quadrant), 0);
        check("t5_ticks", int'({sif.Period_tick, sif.Cycle_done}), 0);
        Rst_n      = 1'b1;
        sif.Enable = 1'b0;
        @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
